ddc_cic_mc: RTL and testbench

//  Time-multiplexed multi-channel CIC decimator with runtime-programmable rate.

---
 rtl/ddc_cic_mc_if.sv | 30 +++
 rtl/ddc_cic_mc.sv | 170 +++++++++++++++++
 tb/tb_ddc_cic_mc.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ddc_cic_mc_if.sv
// Sample/control bundle of the multi-channel CIC decimator. The master drives samples,
// rate loads and the enable. The slave (the decimator) returns decimated samples and status.
interface ddc_cic_mc_if #(
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 25,
    parameter int CHW           = 2,
    parameter int RW            = 3
);
    logic                     en_i;
    logic [DATAIN_WIDTH-1:0]  data_i;
    logic [CHW-1:0]           chan_i;
    logic                     act_i;
    logic [RW-1:0]            rate_i;
    logic                     rate_ld_i;
    logic [DATAOUT_WIDTH-1:0] data_o;
    logic [CHW-1:0]           chan_o;
    logic                     val_o;
    logic [RW-1:0]            rate_o;
    logic                     sync_err_o;

    modport master (
        output en_i, data_i, chan_i, act_i, rate_i, rate_ld_i,
        input  data_o, chan_o, val_o, rate_o, sync_err_o
    );

    modport slave (
        input  en_i, data_i, chan_i, act_i, rate_i, rate_ld_i,
        output data_o, chan_o, val_o, rate_o, sync_err_o
    );
endinterface

// File: rtl/ddc_cic_mc.sv
// Time-multiplexed CIC decimator. One integrator/comb datapath is shared by CIC_NCH
// round-robin channels, and the decimation rate can be changed at runtime.
module ddc_cic_mc #(
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 25,
    parameter int CIC_NCH       = 4,
    parameter int CIC_M         = 2,
    parameter int CIC_N         = 5,
    parameter int CIC_MAXRATE   = 5
) (
    input logic          clk_i,
    input logic          rst_i,
    ddc_cic_mc_if.slave  bus
);
    localparam int CHW = (CIC_NCH > 1) ? $clog2(CIC_NCH) : 1;
    localparam int RW  = $clog2(CIC_MAXRATE + 1);
    localparam int W   = DATAIN_WIDTH + CIC_N * $clog2(CIC_MAXRATE * CIC_M);

    localparam logic [CHW-1:0] LAST_CH  = CHW'(CIC_NCH - 1);
    localparam logic [RW-1:0]  MAX_RATE = RW'(CIC_MAXRATE);

    // Handshake: act_i qualifies data_i/chan_i for exactly one cycle with no backpressure;
    // val_o qualifies data_o/chan_o for exactly one cycle. Both count only while en_i=1.

    logic [CHW-1:0] exp_ch;
    logic [RW-1:0]  fcnt;
    logic [RW-1:0]  rate_r;
    logic [RW-1:0]  pend_rate;
    logic           pend_vld;
    logic           sync_err;

    logic [W-1:0]   integ [CIC_NCH][CIC_N];
    logic [W-1:0]   dly   [CIC_NCH][CIC_N][CIC_M];

    logic [W-1:0]   pipe_dat [CIC_N+1];
    logic [CHW-1:0] pipe_ch  [CIC_N+1];
    logic [CIC_N:0] pipe_val;

    logic [DATAOUT_WIDTH-1:0] out_dat;
    logic [CHW-1:0]           out_ch;
    logic                     out_val;

    logic                     accept;
    logic                     boundary;
    logic                     dump;
    logic                     ld_ok;
    logic [W-1:0]             x_ext;
    logic [W-1:0]             acc [CIC_N];
    logic [DATAOUT_WIDTH-1:0] trunc;

    assign ld_ok    = bus.rate_ld_i && (bus.rate_i != '0) && (bus.rate_i <= MAX_RATE);
    assign accept   = bus.en_i && bus.act_i && (bus.chan_i == exp_ch);
    assign boundary = accept && (exp_ch == LAST_CH);
    assign dump     = (fcnt == rate_r - RW'(1));
    assign x_ext    = W'($signed(bus.data_i));

    // Whole integrator cascade for the current channel settles in one cycle.
    always_comb begin
        acc[0] = integ[exp_ch][0] + x_ext;
        for (int k = 1; k < CIC_N; k++) begin
            acc[k] = integ[exp_ch][k] + acc[k-1];
        end
    end

    generate
        if (W >= DATAOUT_WIDTH) begin : g_trunc
            assign trunc = pipe_dat[CIC_N][W-1 -: DATAOUT_WIDTH];
        end else begin : g_pad
            assign trunc = {pipe_dat[CIC_N], {(DATAOUT_WIDTH - W){1'b0}}};
        end
    endgenerate

    // Channel sequencing, frame counting and rate switching.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exp_ch    <= '0;
            fcnt      <= '0;
            rate_r    <= MAX_RATE;
            pend_rate <= MAX_RATE;
            pend_vld  <= 1'b0;
            sync_err  <= 1'b0;
        end else if (bus.en_i) begin
            if (bus.act_i && !accept) begin
                sync_err <= 1'b1;
            end
            if (accept) begin
                exp_ch <= (exp_ch == LAST_CH) ? '0 : exp_ch + CHW'(1);
            end
            if (boundary) begin
                // A load arriving with the completing sample still takes effect for the next frame.
                if (ld_ok) begin
                    rate_r   <= bus.rate_i;
                    fcnt     <= '0;
                    pend_vld <= 1'b0;
                end else if (pend_vld) begin
                    rate_r   <= pend_rate;
                    fcnt     <= '0;
                    pend_vld <= 1'b0;
                end else begin
                    fcnt <= dump ? '0 : fcnt + RW'(1);
                end
            end else if (ld_ok) begin
                if (exp_ch == '0 && !accept) begin
                    rate_r   <= bus.rate_i;
                    fcnt     <= '0;
                    pend_vld <= 1'b0;
                end else begin
                    pend_rate <= bus.rate_i;
                    pend_vld  <= 1'b1;
                end
            end
        end
    end

    // Integrators, comb pipeline with per-channel delay lines, and output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < CIC_NCH; c++) begin
                for (int k = 0; k < CIC_N; k++) begin
                    integ[c][k] <= '0;
                    for (int m = 0; m < CIC_M; m++) begin
                        dly[c][k][m] <= '0;
                    end
                end
            end
            for (int s = 0; s <= CIC_N; s++) begin
                pipe_dat[s] <= '0;
                pipe_ch[s]  <= '0;
            end
            pipe_val <= '0;
            out_dat  <= '0;
            out_ch   <= '0;
            out_val  <= 1'b0;
        end else if (bus.en_i) begin
            if (accept) begin
                for (int k = 0; k < CIC_N; k++) begin
                    integ[exp_ch][k] <= acc[k];
                end
                pipe_dat[0] <= acc[CIC_N-1];
                pipe_ch[0]  <= exp_ch;
            end
            pipe_val[0] <= accept && dump;

            for (int s = 1; s <= CIC_N; s++) begin
                pipe_val[s] <= pipe_val[s-1];
                pipe_ch[s]  <= pipe_ch[s-1];
                pipe_dat[s] <= pipe_dat[s-1] - dly[pipe_ch[s-1]][s-1][CIC_M-1];
                if (pipe_val[s-1]) begin
                    dly[pipe_ch[s-1]][s-1][0] <= pipe_dat[s-1];
                    for (int m = 1; m < CIC_M; m++) begin
                        dly[pipe_ch[s-1]][s-1][m] <= dly[pipe_ch[s-1]][s-1][m-1];
                    end
                end
            end

            out_val <= pipe_val[CIC_N];
            if (pipe_val[CIC_N]) begin
                out_dat <= trunc;
                out_ch  <= pipe_ch[CIC_N];
            end
        end
    end

    // A held output sample is shown exactly once: in the first enabled cycle it is present.
    assign bus.val_o      = out_val & bus.en_i;
    assign bus.data_o     = out_dat;
    assign bus.chan_o     = out_ch;
    assign bus.rate_o     = rate_r;
    assign bus.sync_err_o = sync_err;
endmodule

// File: tb/tb_ddc_cic_mc.sv
// Directed bench for the multi-channel CIC decimator (4 channels, N=5, M=2, max rate 5).
// Expected values are worked out by hand from the CIC gain and pipeline latency.
module tb_ddc_cic_mc;
    localparam int DIW = 16;
    localparam int DOW = 25;
    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int RW  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddc_cic_mc_if #(.DATAIN_WIDTH(DIW), .DATAOUT_WIDTH(DOW), .CHW(CHW), .RW(RW)) bus ();

    ddc_cic_mc #(
        .DATAIN_WIDTH(DIW), .DATAOUT_WIDTH(DOW), .CIC_NCH(NCH),
        .CIC_M(2), .CIC_N(5), .CIC_MAXRATE(5)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int nval  = 0;
    int vcnt   [NCH];
    int vlast  [NCH];
    int vfirst [NCH];
    int vint   [NCH];
    int vdat   [NCH];

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive sample inputs, pass the edge, then sample outputs 1 ns later.
    task automatic step(input logic act, input int ch, input int dat);
        int c;
        bus.act_i  = act;
        bus.chan_i = CHW'(ch);
        bus.data_i = DIW'(dat);
        @(posedge clk);
        #1;
        cyc++;
        if (bus.val_o === 1'b1) begin
            c = int'(bus.chan_o);
            if (vcnt[c] == 0) vfirst[c] = cyc;
            else vint[c] = cyc - vlast[c];
            vcnt[c]++;
            vlast[c] = cyc;
            vdat[c]  = int'($signed(bus.data_o));
            nval++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0);
    endtask

    task automatic frames(input int n, input int d0, input int d2);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < NCH; c++) begin
                step(1'b1, c, (c == 0) ? d0 : ((c == 2) ? d2 : 0));
            end
        end
        bus.act_i = 1'b0;
    endtask

    task automatic load_rate(input int r);
        bus.rate_i    = RW'(r);
        bus.rate_ld_i = 1'b1;
        step(1'b0, 0, 0);
        bus.rate_ld_i = 1'b0;
    endtask

    int c0, n0, n1, nv, ta;

    initial begin
        rst = 1'b1;
        bus.en_i = 1'b1; bus.act_i = 1'b0; bus.chan_i = '0; bus.data_i = '0;
        bus.rate_i = '0; bus.rate_ld_i = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            vcnt[c] = 0; vlast[c] = 0; vfirst[c] = 0; vint[c] = 0; vdat[c] = 0;
        end
        idle(3);
        rst = 1'b0;

        // Reset state and quiet idle
        check("rst_data", int'($signed(bus.data_o)), 0);
        check("rst_chan", int'(bus.chan_o), 0);
        check("rst_val", int'(bus.val_o), 0);
        check("rst_rate", int'(bus.rate_o), 5);
        check("rst_err", int'(bus.sync_err_o), 0);
        idle(200);
        check("idle_no_val", nval, 0);

        // Rate loads outside 1..5 are ignored; valid loads apply at once between frames
        load_rate(0);
        check("ld_zero_ignored", int'(bus.rate_o), 5);
        load_rate(6);
        check("ld_over_ignored", int'(bus.rate_o), 5);
        load_rate(3);
        check("ld_idle_immediate", int'(bus.rate_o), 3);
        load_rate(5);
        check("ld_back_to_5", int'(bus.rate_o), 5);

        // DC at rate 5: gain 10^5, 1000*1e5 >> 11 = 48828
        c0 = cyc;
        frames(60, 1000, 0);
        idle(10);
        check("dc_cnt0", vcnt[0], 12);
        check("dc_cnt3", vcnt[3], 12);
        check("dc_lat_ch0", vfirst[0], c0 + 23);
        check("dc_lat_ch3", vfirst[3], c0 + 26);
        check("dc_val0", vdat[0], 48828);
        check("dc_val1", vdat[1], 0);
        check("dc_val3", vdat[3], 0);
        check("dc_period0", vint[0], 20);
        check("dc_period3", vint[3], 20);

        // Rate change to 2 mid-frame: takes effect only after channel 3
        step(1'b1, 0, 1000);
        step(1'b1, 1, 0);
        bus.rate_i = RW'(2); bus.rate_ld_i = 1'b1;
        step(1'b1, 2, 0);
        bus.rate_ld_i = 1'b0;
        check("rate_pending", int'(bus.rate_o), 5);
        step(1'b1, 3, 0);
        bus.act_i = 1'b0;
        check("rate_at_boundary", int'(bus.rate_o), 2);
        n0 = vcnt[0];
        frames(60, 1000, 0);
        idle(10);
        check("r2_cnt0", vcnt[0] - n0, 30);
        check("r2_val0", vdat[0], 500);
        check("r2_val2", vdat[2], 0);
        check("r2_period0", vint[0], 8);
        check("r2_period1", vint[1], 8);

        // Sequence error: ch2 after ch0 is dropped, ch1 is then accepted
        step(1'b1, 0, 1000);
        step(1'b1, 2, 0);
        check("seq_err_set", int'(bus.sync_err_o), 1);
        n1 = vcnt[1];
        step(1'b1, 1, 0);
        step(1'b1, 2, 0);
        step(1'b1, 3, 0);
        frames(20, 1000, 0);
        idle(10);
        check("seq_resume_cnt1", vcnt[1] - n1, 10);
        check("seq_err_sticky", int'(bus.sync_err_o), 1);
        check("seq_val0", vdat[0], 500);

        // 10-cycle stall inside a dumping frame: everything shifts by 10
        ta = cyc;
        step(1'b1, 0, 1000);
        step(1'b1, 1, 0);
        nv = nval;
        bus.en_i = 1'b0;
        bus.rate_i = RW'(1); bus.rate_ld_i = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, 2, 12345);
        bus.rate_ld_i = 1'b0;
        check("stall_no_val", nval - nv, 0);
        bus.en_i = 1'b1;
        step(1'b1, 2, 0);
        step(1'b1, 3, 0);
        idle(10);
        check("stall_lat0", vlast[0], ta + 17);
        check("stall_lat1", vlast[1], ta + 18);
        check("stall_lat3", vlast[3], ta + 20);
        check("stall_val0", vdat[0], 500);
        check("stall_ld_ignored", int'(bus.rate_o), 2);

        // Full-scale negative input at rate 5, plus ch2=2048 -> 100000
        rst = 1'b1;
        step(1'b0, 0, 0);
        rst = 1'b0;
        check("rst2_err", int'(bus.sync_err_o), 0);
        check("rst2_rate", int'(bus.rate_o), 5);
        check("rst2_data", int'($signed(bus.data_o)), 0);
        frames(60, -32768, 2048);
        idle(10);
        check("neg_val0", vdat[0], -1600000);
        check("pos_val2", vdat[2], 100000);
        check("zero_val1", vdat[1], 0);

        // Reset in the middle of a dumping frame leaves nothing in flight
        frames(4, -32768, 2048);
        step(1'b1, 0, -32768);
        step(1'b1, 1, 0);
        rst = 1'b1;
        step(1'b1, 2, 2048);
        rst = 1'b0;
        bus.act_i = 1'b0;
        nv = nval;
        idle(30);
        check("no_stale_val", nval - nv, 0);
        check("rst3_data", int'($signed(bus.data_o)), 0);
        check("rst3_chan", int'(bus.chan_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
